// File: rtl/breath_led_ctrl.sv
// Status LED mode controller: OFF, triangular breathing ramp, and alarm blink
// bursts, driving a registered glitch-free PWM output.
module breath_led_ctrl #(
  parameter int TICK_DIV      = 50,
  parameter int DUTY_MAX      = 1000,
  parameter int BLINK_PERIODS = 250,
  parameter int ALARM_BLINKS  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       breathe_en,
  input  logic       alarm_req,
  input  logic       alarm_clr,
  output logic       pwm,
  output logic [9:0] duty,
  output logic [1:0] state,
  output logic       alarm_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_PERIODS + 1);
  localparam int AW = $clog2(ALARM_BLINKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    DMAX       = 10'(DUTY_MAX);
  localparam logic [9:0]    PHASE_LAST = 10'(DUTY_MAX - 1);
  localparam logic [BW-1:0] PER_LAST   = BW'(BLINK_PERIODS - 1);
  localparam logic [AW-1:0] BLINK_LAST = AW'(ALARM_BLINKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BREATHE = 2'd1,
    ALARM   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    duty_q, duty_d;
  logic [9:0]    phase_q, phase_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] perCnt_q, perCnt_d;
  logic [AW-1:0] blinkCnt_q, blinkCnt_d;
  logic          dirDown_q, dirDown_d;
  logic          pwm_q, pwm_d;
  logic          done_q, done_d;

  logic tick, pb;
  logic enterIdle, enterBreathe, enterAlarm, exitAlarm;

  assign tick = (presc_q == PRESC_LAST);
  assign pb   = tick && (phase_q == PHASE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      phase_q    <= '0;
      presc_q    <= '0;
      perCnt_q   <= '0;
      blinkCnt_q <= '0;
      dirDown_q  <= 1'b0;
      pwm_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      phase_q    <= phase_d;
      presc_q    <= presc_d;
      perCnt_q   <= perCnt_d;
      blinkCnt_q <= blinkCnt_d;
      dirDown_q  <= dirDown_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    dirDown_d    = dirDown_q;
    presc_d      = tick ? '0 : presc_q + 1'b1;
    phase_d      = tick ? (pb ? '0 : phase_q + 10'd1) : phase_q;
    perCnt_d     = perCnt_q;
    blinkCnt_d   = blinkCnt_q;
    done_d       = 1'b0;
    pwm_d        = (state_q != IDLE) && (phase_q < duty_q);
    enterIdle    = 1'b0;
    enterBreathe = 1'b0;
    enterAlarm   = 1'b0;
    exitAlarm    = 1'b0;

    case (state_q)
      IDLE: begin
        if (alarm_req)       enterAlarm   = 1'b1;
        else if (breathe_en) enterBreathe = 1'b1;
      end
      BREATHE: begin
        if (alarm_req)        enterAlarm = 1'b1;
        else if (!breathe_en) enterIdle  = 1'b1;
        else if (pb) begin
          if (!dirDown_q) begin
            duty_d = duty_q + 10'd1;
            if (duty_q + 10'd1 == DMAX) dirDown_d = 1'b1;
          end else begin
            duty_d = duty_q - 10'd1;
            if (duty_q == 10'd1) dirDown_d = 1'b0;
          end
        end
      end
      ALARM: begin
        if (alarm_clr)      exitAlarm  = 1'b1;
        else if (alarm_req) enterAlarm = 1'b1;
        else if (pb) begin
          if (perCnt_q == PER_LAST) begin
            perCnt_d = '0;
            // A burst ends only after its last off phase has fully elapsed.
            if (duty_q == 10'd0) begin
              if (blinkCnt_q == BLINK_LAST) begin
                done_d    = 1'b1;
                exitAlarm = 1'b1;
              end else begin
                blinkCnt_d = blinkCnt_q + 1'b1;
                duty_d     = DMAX;
              end
            end else begin
              duty_d = '0;
            end
          end else begin
            perCnt_d = perCnt_q + 1'b1;
          end
        end
      end
      default: enterIdle = 1'b1;
    endcase

    if (exitAlarm) begin
      if (breathe_en) enterBreathe = 1'b1;
      else            enterIdle    = 1'b1;
    end

    if (enterIdle || enterBreathe || enterAlarm) begin
      presc_d    = '0;
      phase_d    = '0;
      perCnt_d   = '0;
      blinkCnt_d = '0;
      dirDown_d  = 1'b0;
      state_d    = enterAlarm ? ALARM : (enterBreathe ? BREATHE : IDLE);
      duty_d     = enterAlarm ? DMAX : 10'd0;
    end
  end

  assign pwm        = pwm_q;
  assign duty       = duty_q;
  assign state      = state_q;
  assign alarm_done = done_q;

endmodule
